// File: rtl/compare_sequencer.sv
// Bit-serial unsigned comparator shared by two requesters under round-robin arbitration.
// The operands are walked MSB-first, and the walk stops at the first differing bit.
module compare_sequencer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic             last_id;
  logic             cur_id;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic             win_id;
  logic             bit_a;
  logic             bit_b;

  // On a tie, the winner is the requester that was not served last.
  always_comb begin
    win_id = req1;
    if (req0 && req1) win_id = ~last_id;
    bit_a = a_l[idx];
    bit_b = b_l[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_id <= 1'b1;
      cur_id  <= 1'b0;
      idx     <= '0;
      a_l     <= '0;
      b_l     <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            a_l     <= win_id ? a1 : a0;
            b_l     <= win_id ? b1 : b0;
            idx     <= IDX_W'(WIDTH - 1);
            cur_id  <= win_id;
            last_id <= win_id;
            gnt0    <= ~win_id;
            gnt1    <= win_id;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_a != bit_b) begin
            gt      <= bit_a;
            lt      <= bit_b;
            eq      <= 1'b0;
            done_id <= cur_id;
            done    <= 1'b1;
            state   <= DONE;
          end else if (idx == '0) begin
            gt      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b1;
            done_id <= cur_id;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
